// File: rtl/hamming_pkg.sv
// Shared constants, FSM state type and reference encoder for the Hamming(16,11) SECDED serial link.
package hamming_pkg;

    localparam int unsigned CW_W   = 16;
    localparam int unsigned DATA_W = 11;
    localparam int unsigned SYN_W  = 4;

    // Codeword bit position of each payload bit d[k]
    localparam int unsigned DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDecode
    } state_e;

    function automatic logic [CW_W-1:0] ham_encode(input logic [DATA_W-1:0] data);
        logic [CW_W-1:0] cw;
        cw = '0;
        for (int k = 0; k < DATA_W; k++) begin
            cw[DATA_POS[k]] = data[k];
        end
        for (int p = 1; p < CW_W; p = p * 2) begin
            for (int i = 1; i < CW_W; i++) begin
                if (((i & p) != 0) && (i != p)) begin
                    cw[p] = cw[p] ^ cw[i];
                end
            end
        end
        cw[0] = ^cw[CW_W-1:1];
        return cw;
    endfunction

endpackage

// File: rtl/hamming_secded_dec.sv
// Combinational SECDED decoder: syndrome/parity check, single-bit fix, payload extraction.
module hamming_secded_dec
    import hamming_pkg::*;
(
    input  logic [CW_W-1:0]   cw_i,
    output logic [DATA_W-1:0] data_o,
    output logic              corr_o,
    output logic              dbl_o
);

    logic [SYN_W-1:0] syn;
    logic             par;
    logic [CW_W-1:0]  fixed;

    always_comb begin
        syn = '0;
        for (int i = 1; i < CW_W; i++) begin
            if (cw_i[i]) begin
                syn = syn ^ SYN_W'(i);
            end
        end
        par    = ^cw_i;
        fixed  = cw_i;
        corr_o = 1'b0;
        dbl_o  = 1'b0;
        if (syn != '0 && par) begin
            fixed[syn] = ~cw_i[syn];
            corr_o     = 1'b1;
        end else if (syn == '0 && par) begin
            // Overall parity bit itself was hit; payload is already intact
            corr_o = 1'b1;
        end else if (syn != '0 && !par) begin
            dbl_o = 1'b1;
        end
        for (int k = 0; k < DATA_W; k++) begin
            data_o[k] = fixed[DATA_POS[k]];
        end
    end

endmodule

// File: rtl/hamming_secded_serial_rx.sv
// Serial SECDED receiver: start-bit framing, 16-bit deserialiser with inter-bit timeout,
// single-entry valid/ready output buffer and saturating error counters.
module hamming_secded_serial_rx
    import hamming_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              bit_in,
    input  logic              out_ready,
    input  logic              clr_cnt,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_corr,
    output logic              out_dbl,
    output logic              overrun,
    output logic              frame_err,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  dbl_cnt
);

    localparam int unsigned TmrW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYC - 1);

    state_e              state_q, state_d;
    logic [CW_W-1:0]     sr_q, sr_d;
    logic [3:0]          idx_q, idx_d;
    logic [TmrW-1:0]     tmr_q, tmr_d;
    logic                buf_valid_q, buf_valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                corr_q, corr_d;
    logic                dbl_q, dbl_d;
    logic                overrun_q, overrun_d;
    logic                frame_err_q, frame_err_d;
    logic [CNT_W-1:0]    corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0]    dbl_cnt_q, dbl_cnt_d;

    logic [DATA_W-1:0]   dec_data;
    logic                dec_corr;
    logic                dec_dbl;
    logic                buf_we;
    logic                pop;
    logic                can_write;

    hamming_secded_dec u_dec (
        .cw_i   (sr_q),
        .data_o (dec_data),
        .corr_o (dec_corr),
        .dbl_o  (dec_dbl)
    );

    assign pop       = buf_valid_q & out_ready;
    assign can_write = ~buf_valid_q | out_ready;

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        idx_d       = idx_q;
        tmr_d       = tmr_q;
        buf_we      = 1'b0;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bit_en && bit_in) begin
                    state_d = StShift;
                    idx_d   = '0;
                    tmr_d   = '0;
                end
            end
            StShift: begin
                if (bit_en) begin
                    // c0 arrives first, so after 16 shifts it sits at bit 0
                    sr_d  = {bit_in, sr_q[CW_W-1:1]};
                    idx_d = idx_q + 4'd1;
                    tmr_d = '0;
                    if (idx_q == 4'd15) begin
                        state_d = StDecode;
                    end
                end else if (tmr_q == TmrLast) begin
                    state_d     = StIdle;
                    frame_err_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end
            StDecode: begin
                state_d = StIdle;
                if (can_write) begin
                    buf_we = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        buf_valid_d = buf_valid_q & ~pop;
        data_d      = data_q;
        corr_d      = corr_q;
        dbl_d       = dbl_q;
        if (buf_we) begin
            buf_valid_d = 1'b1;
            data_d      = dec_data;
            corr_d      = dec_corr;
            dbl_d       = dec_dbl;
        end

        corr_cnt_d = corr_cnt_q;
        dbl_cnt_d  = dbl_cnt_q;
        if (clr_cnt) begin
            corr_cnt_d = '0;
            dbl_cnt_d  = '0;
        end else if (buf_we) begin
            if (dec_corr && corr_cnt_q != '1) begin
                corr_cnt_d = corr_cnt_q + CNT_W'(1);
            end
            if (dec_dbl && dbl_cnt_q != '1) begin
                dbl_cnt_d = dbl_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sr_q        <= '0;
            idx_q       <= '0;
            tmr_q       <= '0;
            buf_valid_q <= 1'b0;
            data_q      <= '0;
            corr_q      <= 1'b0;
            dbl_q       <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            corr_cnt_q  <= '0;
            dbl_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            idx_q       <= idx_d;
            tmr_q       <= tmr_d;
            buf_valid_q <= buf_valid_d;
            data_q      <= data_d;
            corr_q      <= corr_d;
            dbl_q       <= dbl_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            corr_cnt_q  <= corr_cnt_d;
            dbl_cnt_q   <= dbl_cnt_d;
        end
    end

    assign out_valid = buf_valid_q;
    assign out_data  = data_q;
    assign out_corr  = corr_q;
    assign out_dbl   = dbl_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign corr_cnt  = corr_cnt_q;
    assign dbl_cnt   = dbl_cnt_q;

endmodule
